neuron_buffer_scheduler: RTL and testbench
==========================================

NEURON_BUFFER_SCHEDULER -- requirements
Module: neuron_buffer_scheduler

Interface
REQ-001: Parameter A, default 7, neuron buffer address width.
REQ-002: Parameter L, default 4, layer-count width.
REQ-003: clk  input  1  single clock; all state updates on rising edge.
REQ-004: reset  input  1  synchronous, active-high reset.
REQ-005: start  input  1  one-cycle run request; honoured only in IDLE.
REQ-006: numLayers  input  L  layers per run; sampled on accepted start.
REQ-007: readLen  input  A  words read per layer; sampled on accepted start.
REQ-008: writeLen  input  A  words written per layer; sampled on accepted start.
REQ-009: readReady  input  1  conv-side consumer accepts the current read address.
REQ-010: writeValid  input  1  pool unit presents one output word.
REQ-011: readBufferSelect  output  1  0 = N1 is read buffer, 1 = N2 is read buffer; registered.
REQ-012: readBuffAddress  output  A  current read address; registered.
REQ-013: writeBuffAddress  output  A  current write address; registered.
REQ-014: readValid  output  1  read address valid this cycle.
REQ-015: writeEnable  output  1  write-buffer strobe, combinational from writeValid gating.
REQ-016: layerIndex  output  L  layer in progress, 0-based; registered.
REQ-017: busy  output  1  high in every state except IDLE.
REQ-018: done  output  1  one-cycle pulse at run completion.
REQ-019: writeOverflow  output  1  sticky flag: writeValid arrived with no write slot left.

Function
REQ-020: FSM states IDLE, READ, DRAIN, SWAP, DONE; one state per cycle minimum.
REQ-021: IDLE: start=1 and numLayers!=0 -> READ next cycle; latch config, clear addresses, layerIndex=0, clear writeOverflow.
REQ-022: IDLE: start=1 and numLayers=0 -> DONE directly; readBufferSelect unchanged.
REQ-023: start outside IDLE is ignored without side effects.
REQ-024: readValid = 1 only in READ, and only while readBuffAddress < readLen.
REQ-025: READ: readValid and readReady -> readBuffAddress increments.
REQ-026: Accepting address readLen-1 -> DRAIN next cycle; readLen=0 -> READ lasts exactly one cycle, no readValid, then DRAIN.
REQ-027: writeEnable = writeValid AND state in {READ, DRAIN} AND write count < writeLen.
REQ-028: writeBuffAddress increments on each writeEnable; writes can overlap reads.
REQ-029: writeValid in READ/DRAIN with write count = writeLen -> word dropped, writeOverflow set; it stays set until reset or next accepted start.
REQ-030: writeValid in IDLE, SWAP or DONE -> ignored, writeOverflow unaffected.
REQ-031: DRAIN: write count = writeLen -> SWAP next cycle; a final write in DRAIN counts in the same cycle.
REQ-032: SWAP (one cycle): toggle readBufferSelect; clear readBuffAddress and writeBuffAddress.
REQ-033: SWAP with layerIndex = numLayers-1 -> DONE; otherwise layerIndex increments and -> READ.
REQ-034: DONE: done=1 for exactly one cycle -> IDLE.
REQ-035: readBufferSelect holds across runs, so the last-written buffer is left as the read buffer for IO readout.
REQ-036: Address counters are A bits wide and never exceed readLen/writeLen, so no wrap-around occurs.

Reset
REQ-037: reset=1 at any edge, including mid-run -> IDLE; readBufferSelect=0, addresses=0, layerIndex=0, writeOverflow=0.
REQ-038: While reset=1: readValid=0, writeEnable=0, busy=0, done=0; start in the reset cycle is ignored.

Verification
REQ-039: numLayers=2, readLen=4, writeLen=2, readReady=1, two writeValid pulses per layer -> readValid 4 cycles per layer; select 0->1->0; layerIndex 0,1; done pulses once; total time 14 cycles from start.
REQ-040: readReady toggling 1,0,1,0 -> readBuffAddress advances only on readReady=1 cycles; no address skipped or repeated.
REQ-041: writeLen=1, three writeValid pulses in READ -> one writeEnable at address 0; writeOverflow=1 until next start.
REQ-042: numLayers=0 start -> done one cycle later; busy high for 1 cycle; readBufferSelect unchanged.
REQ-043: Reset asserted in DRAIN of layer 1 -> next cycle in IDLE: select=0, busy=0, no done pulse.
REQ-044: readLen=0, writeLen=0, numLayers=1 -> READ, DRAIN, SWAP, DONE in consecutive cycles; select toggles once.

Source files
------------

// File: rtl/neuron_buffer_scheduler.sv
// Ping-pong neuron buffer scheduler: streams read addresses out of one buffer while
// pool results land in the other, then swaps the buffers for each layer of a run.
module neuron_buffer_scheduler #(
  parameter int A = 7,
  parameter int L = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [L-1:0] numLayers,
  input  logic [A-1:0] readLen,
  input  logic [A-1:0] writeLen,
  input  logic         readReady,
  input  logic         writeValid,
  output logic         readBufferSelect,
  output logic [A-1:0] readBuffAddress,
  output logic [A-1:0] writeBuffAddress,
  output logic         readValid,
  output logic         writeEnable,
  output logic [L-1:0] layerIndex,
  output logic         busy,
  output logic         done,
  output logic         writeOverflow
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_SWAP,
    S_DONE
  } state_t;

  state_t       state_q, state_d;
  logic [L-1:0] num_layers_q, num_layers_d;
  logic [A-1:0] read_len_q, read_len_d;
  logic [A-1:0] write_len_q, write_len_d;
  logic [A-1:0] read_addr_q, read_addr_d;
  logic [A-1:0] write_addr_q, write_addr_d;
  logic [L-1:0] layer_q, layer_d;
  logic         sel_q, sel_d;
  logic         ovf_q, ovf_d;

  logic         read_valid;
  logic         write_active;
  logic         write_en;

  // NOTE: every _d gets its current _q value first, so no path through the case
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    num_layers_d = num_layers_q;
    read_len_d   = read_len_q;
    write_len_d  = write_len_q;
    read_addr_d  = read_addr_q;
    write_addr_d = write_addr_q;
    layer_d      = layer_q;
    sel_d        = sel_q;
    ovf_d        = ovf_q;

    read_valid   = (state_q == S_READ) && (read_addr_q < read_len_q);
    write_active = (state_q == S_READ) || (state_q == S_DRAIN);
    write_en     = writeValid && write_active && (write_addr_q < write_len_q);

    // The write address doubles as the count of words accepted this layer.
    if (write_en) begin
      write_addr_d = write_addr_q + A'(1);
    end
    if (writeValid && write_active && !(write_addr_q < write_len_q)) begin
      ovf_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (numLayers != '0) begin
            state_d      = S_READ;
            num_layers_d = numLayers;
            read_len_d   = readLen;
            write_len_d  = writeLen;
            read_addr_d  = '0;
            write_addr_d = '0;
            layer_d      = '0;
            ovf_d        = 1'b0;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_READ: begin
        if (read_len_q == '0) begin
          state_d = S_DRAIN;
        end else if (read_valid && readReady) begin
          read_addr_d = read_addr_q + A'(1);
          if (read_addr_q == read_len_q - A'(1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Compare the post-update count so a final write in this cycle finishes the layer.
        if (write_addr_d == write_len_q) begin
          state_d = S_SWAP;
        end
      end
      S_SWAP: begin
        sel_d        = ~sel_q;
        read_addr_d  = '0;
        write_addr_d = '0;
        if (layer_q == num_layers_q - L'(1)) begin
          state_d = S_DONE;
        end else begin
          layer_d = layer_q + L'(1);
          state_d = S_READ;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      num_layers_q <= '0;
      read_len_q   <= '0;
      write_len_q  <= '0;
      read_addr_q  <= '0;
      write_addr_q <= '0;
      layer_q      <= '0;
      sel_q        <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_layers_q <= num_layers_d;
      read_len_q   <= read_len_d;
      write_len_q  <= write_len_d;
      read_addr_q  <= read_addr_d;
      write_addr_q <= write_addr_d;
      layer_q      <= layer_d;
      sel_q        <= sel_d;
      ovf_q        <= ovf_d;
    end
  end

  // Strobes are forced low during the reset cycle even though state updates only at the edge.
  assign readValid        = read_valid && !reset;
  assign writeEnable      = write_en && !reset;
  assign busy             = (state_q != S_IDLE) && !reset;
  assign done             = (state_q == S_DONE) && !reset;
  assign readBufferSelect = sel_q;
  assign readBuffAddress  = read_addr_q;
  assign writeBuffAddress = write_addr_q;
  assign layerIndex       = layer_q;
  assign writeOverflow    = ovf_q;

endmodule

// File: tb/tb_neuron_buffer_scheduler.sv
// Directed bench for neuron_buffer_scheduler: hand-computed expectations for
// multi-layer runs, read back-pressure, write overflow, empty runs and mid-run reset.
module tb_neuron_buffer_scheduler;
  localparam int A = 7;
  localparam int L = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [L-1:0] numLayers;
  logic [A-1:0] readLen;
  logic [A-1:0] writeLen;
  logic         readReady;
  logic         writeValid;
  logic         readBufferSelect;
  logic [A-1:0] readBuffAddress;
  logic [A-1:0] writeBuffAddress;
  logic         readValid;
  logic         writeEnable;
  logic [L-1:0] layerIndex;
  logic         busy;
  logic         done;
  logic         writeOverflow;

  int n_checks = 0;
  int n_errors = 0;
  int rv_cnt, we_cnt, done_cnt, busy_cnt;

  neuron_buffer_scheduler #(.A(A), .L(L)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .numLayers        (numLayers),
    .readLen          (readLen),
    .writeLen         (writeLen),
    .readReady        (readReady),
    .writeValid       (writeValid),
    .readBufferSelect (readBufferSelect),
    .readBuffAddress  (readBuffAddress),
    .writeBuffAddress (writeBuffAddress),
    .readValid        (readValid),
    .writeEnable      (writeEnable),
    .layerIndex       (layerIndex),
    .busy             (busy),
    .done             (done),
    .writeOverflow    (writeOverflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input string tag, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      #1;
      if (done) seen = 1'b1;
    end
    check(tag, seen, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; numLayers = '0; readLen = '0; writeLen = '0;
    readReady = 1'b0; writeValid = 1'b0;

    // Reset state
    tick(); tick(); #1;
    check("rst_busy", busy, 0);
    check("rst_rvalid", readValid, 0);
    check("rst_wen", writeEnable, 0);
    check("rst_done", done, 0);
    check("rst_sel", readBufferSelect, 0);
    check("rst_raddr", readBuffAddress, 0);
    check("rst_waddr", writeBuffAddress, 0);
    check("rst_layer", layerIndex, 0);
    check("rst_ovf", writeOverflow, 0);
    reset = 1'b0;

    // Two layers, readLen 4, writeLen 2, two writes per layer: 14 cycles start to idle
    numLayers = 2; readLen = 4; writeLen = 2; readReady = 1'b1; start = 1'b1;
    #1 check("t39_idle_busy", busy, 0);
    tick(); start = 1'b0;
    rv_cnt = 0; we_cnt = 0; done_cnt = 0; busy_cnt = 0;
    for (int k = 1; k <= 14; k++) begin
      writeValid = (k == 1 || k == 2 || k == 7 || k == 8);
      #1;
      rv_cnt += int'(readValid);
      we_cnt += int'(writeEnable);
      done_cnt += int'(done);
      busy_cnt += int'(busy);
      if (k <= 4) check($sformatf("t39_raddr_c%0d", k), readBuffAddress, k - 1);
      if (k == 5) check("t39_waddr_drain", writeBuffAddress, 2);
      if (k == 7) begin
        check("t39_sel_l1", readBufferSelect, 1);
        check("t39_layer_l1", layerIndex, 1);
        check("t39_waddr_l1", writeBuffAddress, 0);
      end
      if (k == 13) check("t39_done_c13", done, 1);
      if (k == 14) begin
        check("t39_sel_end", readBufferSelect, 0);
        check("t39_busy_end", busy, 0);
      end
      tick();
    end
    writeValid = 1'b0;
    check("t39_rv_cycles", rv_cnt, 8);
    check("t39_we_cycles", we_cnt, 4);
    check("t39_done_pulses", done_cnt, 1);
    check("t39_busy_cycles", busy_cnt, 13);
    check("t39_ovf", writeOverflow, 0);

    // readReady toggling: address advances only on accepted cycles
    numLayers = 1; readLen = 4; writeLen = 1; start = 1'b1;
    tick(); start = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      readReady = (k % 2 == 1);
      writeValid = (k == 1);
      #1;
      check($sformatf("t40_raddr_c%0d", k), readBuffAddress, k / 2);
      check($sformatf("t40_rvalid_c%0d", k), readValid, 1);
      tick();
    end
    readReady = 1'b1; writeValid = 1'b0;
    #1 check("t40_rvalid_drain", readValid, 0);
    wait_done("t40_done_seen", 10);
    check("t40_sel", readBufferSelect, 1);
    tick();

    // numLayers = 0: straight to DONE, select untouched
    numLayers = 0; start = 1'b1;
    tick(); start = 1'b0;
    #1;
    check("t42_done", done, 1);
    check("t42_busy", busy, 1);
    check("t42_sel", readBufferSelect, 1);
    tick(); #1;
    check("t42_done_after", done, 0);
    check("t42_busy_after", busy, 0);
    check("t42_sel_after", readBufferSelect, 1);

    // writeLen 1 with three writes: one accepted, overflow sticky; mid-run start ignored
    numLayers = 1; readLen = 4; writeLen = 1; readReady = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    writeValid = 1'b1; #1;
    check("t41_wen_c1", writeEnable, 1);
    check("t41_waddr_c1", writeBuffAddress, 0);
    tick();
    start = 1'b1; numLayers = 3; #1;
    check("t41_wen_c2", writeEnable, 0);
    tick(); start = 1'b0;
    #1;
    check("t41_wen_c3", writeEnable, 0);
    check("t41_ovf_c3", writeOverflow, 1);
    check("t41_waddr_c3", writeBuffAddress, 1);
    check("t41_layer_c3", layerIndex, 0);
    tick();
    writeValid = 1'b0; readReady = 1'b1; #1;
    check("t41_ovf_c4", writeOverflow, 1);
    wait_done("t41_done_seen", 12);
    check("t41_layer_done", layerIndex, 0);
    check("t41_ovf_done", writeOverflow, 1);
    check("t41_sel_done", readBufferSelect, 0);
    tick();
    writeValid = 1'b1; #1;
    check("t41_wen_idle", writeEnable, 0);
    tick(); writeValid = 1'b0; #1;
    check("t41_ovf_idle", writeOverflow, 1);

    // Reset during layer-1 DRAIN, with a start presented in the reset cycle
    numLayers = 2; readLen = 2; writeLen = 1; readReady = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    writeValid = 1'b1; #1;
    check("t43_ovf_cleared", writeOverflow, 0);
    tick(); writeValid = 1'b0;
    tick(); tick(); tick();
    writeValid = 1'b1; #1;
    check("t43_sel_l1", readBufferSelect, 1);
    check("t43_layer_l1", layerIndex, 1);
    check("t43_wen_l1", writeEnable, 1);
    tick(); #1;
    check("t43_wen_full", writeEnable, 0);
    tick(); writeValid = 1'b0; #1;
    check("t43_ovf_set", writeOverflow, 1);
    check("t43_rvalid_drain", readValid, 0);
    check("t43_busy_drain", busy, 1);
    reset = 1'b1; start = 1'b1; #1;
    check("t43_busy_in_rst", busy, 0);
    check("t43_rvalid_in_rst", readValid, 0);
    check("t43_done_in_rst", done, 0);
    tick(); reset = 1'b0; start = 1'b0; #1;
    check("t43_sel_after", readBufferSelect, 0);
    check("t43_busy_after", busy, 0);
    check("t43_layer_after", layerIndex, 0);
    check("t43_ovf_after", writeOverflow, 0);
    check("t43_waddr_after", writeBuffAddress, 0);
    for (int k = 0; k < 3; k++) begin
      tick(); #1;
      check($sformatf("t43_no_done_%0d", k), done, 0);
      check($sformatf("t43_idle_%0d", k), busy, 0);
    end

    // readLen = 0, writeLen = 0: READ, DRAIN, SWAP, DONE back to back
    numLayers = 1; readLen = 0; writeLen = 0; readReady = 1'b1; start = 1'b1;
    tick(); start = 1'b0; #1;
    check("t44_rvalid_c1", readValid, 0);
    check("t44_busy_c1", busy, 1);
    check("t44_done_c1", done, 0);
    check("t44_sel_c1", readBufferSelect, 0);
    tick(); #1;
    check("t44_rvalid_c2", readValid, 0);
    check("t44_done_c2", done, 0);
    tick(); #1;
    check("t44_done_c3", done, 0);
    check("t44_sel_c3", readBufferSelect, 0);
    check("t44_busy_c3", busy, 1);
    tick(); #1;
    check("t44_done_c4", done, 1);
    check("t44_sel_c4", readBufferSelect, 1);
    tick(); #1;
    check("t44_done_c5", done, 0);
    check("t44_busy_c5", busy, 0);
    check("t44_sel_c5", readBufferSelect, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
